r4_bfly_stream: RTL

Parametrised radix-4 butterfly with a valid/ready stream interface and a two-stage arithmetic pipeline. It replaces the fixed 4-bit single-output butterfly in the FFT datapath. One handshake accepts four complex signed samples. The block computes all four radix-4 DFT outputs, forward or inverse, with full-growth or scaled arithmetic, and emits them serially in natural order under output backpressure.

---
 rtl/r4_pkg.sv | 18 +
 rtl/r4_bfly_stream_if.sv | 33 +++
 rtl/r4_round_shift.sv | 25 ++
 rtl/r4_bfly_stream.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/r4_pkg.sv
// Shared types and helpers for the streaming radix-4 butterfly.
package r4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Bias added before the divide-by-4 so the shift rounds half up.
  localparam int unsigned RND_BIAS = 2;

  function automatic int unsigned ow_of(input int unsigned dw, input int unsigned scale);
    return (scale != 0) ? dw : dw + 2;
  endfunction

endpackage

// File: rtl/r4_bfly_stream_if.sv
// Block-in / serial-out stream bundle of the radix-4 butterfly.
interface r4_bfly_stream_if
  import r4_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned SCALE = 0
);

  localparam int unsigned OW = ow_of(DW, SCALE);

  logic                 in_valid;
  logic                 in_ready;
  logic [4*DW-1:0]      in_re;
  logic [4*DW-1:0]      in_im;
  logic                 inv;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [1:0]           out_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_re, in_im, inv, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, inv, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

endinterface

// File: rtl/r4_round_shift.sv
// Divide one stage-2 component by 4 with round-half-up and clamp to DW bits.
module r4_round_shift
  import r4_pkg::*;
#(
  parameter int unsigned IW = 10,
  parameter int unsigned DW = 8
) (
  input  logic signed [IW-1:0] v,
  output logic signed [DW-1:0] y_c
);

  localparam int unsigned SW = IW + 1;
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (DW - 1)) - 1);

  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] shr_c;

  // Only the positive extreme can exceed DW bits after rounding.
  always_comb begin
    sum_c = SW'(v) + $signed(SW'(RND_BIAS));
    shr_c = sum_c >>> 2;
    y_c   = (shr_c > MAXV) ? DW'(MAXV) : DW'(shr_c);
  end

endmodule

// File: rtl/r4_bfly_stream.sv
// Radix-4 butterfly: accepts four complex samples, two-stage pipeline,
// emits X[0..3] serially under backpressure.
module r4_bfly_stream
  import r4_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned SCALE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  r4_bfly_stream_if.slave bus
);

  localparam int unsigned OW  = ow_of(DW, SCALE);
  localparam int unsigned S1W = DW + 1;
  localparam int unsigned S2W = DW + 2;

  state_e state_q, state_d;

  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q,  out_last_d;
  logic [1:0]           out_idx_q,   out_idx_d;
  logic signed [OW-1:0] out_re_q,    out_re_d;
  logic signed [OW-1:0] out_im_q,    out_im_d;
  logic                 inv_q,       inv_d;

  logic signed [DW-1:0]  x_re_q  [4], x_re_d  [4];
  logic signed [DW-1:0]  x_im_q  [4], x_im_d  [4];
  logic signed [S1W-1:0] s1_re_q [4], s1_re_d [4];
  logic signed [S1W-1:0] s1_im_q [4], s1_im_d [4];
  logic signed [OW-1:0]  rb_re_q [4], rb_re_d [4];
  logic signed [OW-1:0]  rb_im_q [4], rb_im_d [4];

  logic signed [DW-1:0]  in_re_c  [4];
  logic signed [DW-1:0]  in_im_c  [4];
  logic signed [S1W-1:0] st1_re_c [4];
  logic signed [S1W-1:0] st1_im_c [4];
  logic signed [S2W-1:0] st2_re_c [4];
  logic signed [S2W-1:0] st2_im_c [4];
  logic signed [OW-1:0]  res_re_c [4];
  logic signed [OW-1:0]  res_im_c [4];
  logic [1:0]            idx_nx_c;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_re_c[k] = bus.in_re[k*DW +: DW];
      in_im_c[k] = bus.in_im[k*DW +: DW];
    end
  end

  // Stage 1 slots: 0 = a (x0+x2), 1 = b (x0-x2), 2 = c (x1+x3), 3 = d (x1-x3).
  always_comb begin
    st1_re_c[0] = S1W'(x_re_q[0]) + S1W'(x_re_q[2]);
    st1_im_c[0] = S1W'(x_im_q[0]) + S1W'(x_im_q[2]);
    st1_re_c[1] = S1W'(x_re_q[0]) - S1W'(x_re_q[2]);
    st1_im_c[1] = S1W'(x_im_q[0]) - S1W'(x_im_q[2]);
    st1_re_c[2] = S1W'(x_re_q[1]) + S1W'(x_re_q[3]);
    st1_im_c[2] = S1W'(x_im_q[1]) + S1W'(x_im_q[3]);
    st1_re_c[3] = S1W'(x_re_q[1]) - S1W'(x_re_q[3]);
    st1_im_c[3] = S1W'(x_im_q[1]) - S1W'(x_im_q[3]);
  end

  // Stage 2: b - j*d and b + j*d swap between X1 and X3 for the inverse.
  always_comb begin
    logic signed [S2W-1:0] p_re, p_im, m_re, m_im;
    p_re = S2W'(s1_re_q[1]) + S2W'(s1_im_q[3]);
    p_im = S2W'(s1_im_q[1]) - S2W'(s1_re_q[3]);
    m_re = S2W'(s1_re_q[1]) - S2W'(s1_im_q[3]);
    m_im = S2W'(s1_im_q[1]) + S2W'(s1_re_q[3]);
    st2_re_c[0] = S2W'(s1_re_q[0]) + S2W'(s1_re_q[2]);
    st2_im_c[0] = S2W'(s1_im_q[0]) + S2W'(s1_im_q[2]);
    st2_re_c[2] = S2W'(s1_re_q[0]) - S2W'(s1_re_q[2]);
    st2_im_c[2] = S2W'(s1_im_q[0]) - S2W'(s1_im_q[2]);
    st2_re_c[1] = inv_q ? m_re : p_re;
    st2_im_c[1] = inv_q ? m_im : p_im;
    st2_re_c[3] = inv_q ? p_re : m_re;
    st2_im_c[3] = inv_q ? p_im : m_im;
  end

  if (SCALE != 0) begin : g_scale
    for (genvar k = 0; k < 4; k++) begin : g_comp
      r4_round_shift #(.IW(S2W), .DW(DW)) u_rs_re (.v(st2_re_c[k]), .y_c(res_re_c[k]));
      r4_round_shift #(.IW(S2W), .DW(DW)) u_rs_im (.v(st2_im_c[k]), .y_c(res_im_c[k]));
    end
  end else begin : g_full
    always_comb begin
      for (int k = 0; k < 4; k++) begin
        res_re_c[k] = OW'(st2_re_c[k]);
        res_im_c[k] = OW'(st2_im_c[k]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    inv_d       = inv_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    rb_re_d     = rb_re_q;
    rb_im_d     = rb_im_q;
    idx_nx_c    = out_idx_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_re_d     = in_re_c;
          x_im_d     = in_im_c;
          inv_d      = bus.inv;
          in_ready_d = 1'b0;
          state_d    = S1;
        end
      end
      S1: begin
        s1_re_d = st1_re_c;
        s1_im_d = st1_im_c;
        state_d = S2;
      end
      S2: begin
        rb_re_d     = res_re_c;
        rb_im_d     = res_im_c;
        out_valid_d = 1'b1;
        out_idx_d   = 2'd0;
        out_last_d  = 1'b0;
        out_re_d    = res_re_c[0];
        out_im_d    = res_im_c[0];
        state_d     = EMIT;
      end
      EMIT: begin
        // Output register advances only on a completed transfer.
        if (out_valid_q && bus.out_ready) begin
          if (out_idx_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_idx_d   = 2'd0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
          end else begin
            out_idx_d  = idx_nx_c;
            out_last_d = (idx_nx_c == 2'd3);
            out_re_d   = rb_re_q[idx_nx_c];
            out_im_d   = rb_im_q[idx_nx_c];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= 2'd0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      inv_q       <= 1'b0;
      x_re_q      <= '{default: '0};
      x_im_q      <= '{default: '0};
      s1_re_q     <= '{default: '0};
      s1_im_q     <= '{default: '0};
      rb_re_q     <= '{default: '0};
      rb_im_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      inv_q       <= inv_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      rb_re_q     <= rb_re_d;
      rb_im_q     <= rb_im_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;

endmodule
